fp32_to_fp16_packer: RTL and testbench
======================================

// Module: fp32_to_fp16_packer
// PURPOSE
// - Downstream stage of the fp32 multiply-add datapath: accepts its 32-bit fp32 result stream and
//   narrows each word to IEEE fp16 with round-to-nearest-even (RNE), for the fp16 accumulator/store.
// - 2-stage valid/ready pipeline with full backpressure, per-result exception flags and
//   saturating overflow/underflow event counters.
// PARAMETERS
// - SAT_EN  1   1: overflow -> max finite 0x7BFF (signed); 0: overflow -> +/-inf 0x7C00
// - FTZ     0   1: fp16 subnormal results flushed to signed zero (unf+inexact set)
// - CNT_W   16  width of ovf_cnt/unf_cnt
// PORTS
// - clk        in   1      clock, all logic on rising edge
// - rst        in   1      synchronous, active-high reset
// - in_valid   in   1      in_data valid
// - in_ready   out  1      stage accepts in_data this cycle
// - in_data    in   32     fp32 word {sign, exp[7:0], mant[22:0]}
// - out_valid  out  1      out_data/out_flags valid
// - out_ready  in   1      consumer accepts this cycle
// - out_data   out  16     fp16 result
// - out_flags  out  4      {nan, ovf, unf, inexact}
// - cnt_clr    in   1      synchronous clear of both counters
// - ovf_cnt    out  CNT_W  accepted results with ovf set, saturates at all-ones
// - unf_cnt    out  CNT_W  accepted results with unf set, saturates at all-ones
// BEHAVIOUR
// - Reset (rst high at clk edge): both stage valids, out_valid, out_data, out_flags, ovf_cnt and
//   unf_cnt go to 0. in_ready is 0 while rst is high. Reset mid-operation drops in-flight words.
// - Handshake: transfer on valid&&ready. ready_s2 = !v2 || out_ready; in_ready = !rst && (!v1 || ready_s2).
//   Data/valid held stable while out_valid && !out_ready. No loss, no duplication, order preserved.
// - Latency: 2 cycles from input handshake to out_valid when out_ready is held high; throughput 1/clk.
// - Stage 1: register sign, classify (nan/inf/zero/normal), e = E-127, {1,M} plus shift amount.
// - Stage 2: align, RNE, pack, flags.
// - NaN (E=255, M!=0): {s,15'h7E00}, nan=1.
// - Inf (E=255, M=0): {s,15'h7C00}, no flags.
// - E=0: signed zero. If M!=0, set unf=1 and inexact=1.
// - e>15: overflow. Result per SAT_EN; ovf=1, inexact=1.
// - Normal range, -14<=e<=15: exp16=e+15, mant=M[22:13], guard=M[12], sticky=|M[11:0].
//   - Increment when guard && (sticky || mant[0]).
//   - Mantissa carry bumps exp16. exp16 reaching 31 becomes overflow as above.
// - Subnormal range, -25<=e<=-15: shift {1,M} right by (-14-e), then RNE on guard/sticky.
//   - Round-up into 0x0400 is a legal normal result with unf=0.
//   - unf=1 iff the result is subnormal/zero and inexact.
// - e<-25: signed zero, unf=1, inexact=1.
// - inexact = guard|sticky for every finite result.
// - Counters update on the output handshake when the matching flag is set.
//   - cnt_clr wins over a simultaneous increment (counter becomes 0).
//   - Counters stick at all-ones.
// STRUCTURE
// - Shared package fp16_pkg:
//   - constants FP32_BIAS=127, FP16_BIAS=15, FP16_QNAN=15'h7E00, FP16_INF=15'h7C00, FP16_MAXF=15'h7BFF;
//   - typedef fp_flags_t (packed struct nan/ovf/unf/inexact);
//   - typedef fp_class_t enum {FPC_ZERO, FPC_NORM, FPC_INF, FPC_NAN}.
// - One sub-module fp_rne_rounder: combinational (mant[10:0], guard, sticky) -> rounded mant, carry,
//   inexact. Instantiated once in stage 2.
// TESTING
// - Exact: 0x3F800000 -> 0x3C00, flags 0, out_valid exactly 2 clks after handshake.
// - Ties to even:
//   - 0x3F801000 -> 0x3C00, inexact=1.
//   - 0x3F803000 -> 0x3C02, inexact=1.
//   - 0xBF807000 -> 0xBC04, inexact=1.
// - Overflow via rounding: 0x477FF000 -> 0x7BFF (SAT_EN=1) or 0x7C00 (SAT_EN=0), ovf=1, ovf_cnt=1.
// - Subnormals:
//   - 0x33800000 -> 0x0001, flags 0.
//   - 0x33000000 -> 0x0000, unf+inexact.
//   - 0x387FE000 -> 0x0400, unf=0.
// - Specials:
//   - 0xFFC00001 -> 0xFE00, nan=1.
//   - 0x7F800000 -> 0x7C00.
//   - 0x00000001 -> 0x0000, unf+inexact.
// - Backpressure/counters:
//   - Stream 6 words, out_ready low for 5 clks: in_ready falls after 2 held words, in-order output, no loss.
//   - cnt_clr with ovf handshake -> ovf_cnt=0.
//   - rst mid-stream -> out_valid=0 next clk.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared constants and types for the fp32 -> fp16 narrowing stage.
// Flag word order on the wire is {nan, ovf, unf, inexact}.
package fp16_pkg;

    localparam int          FP32_BIAS = 127;
    localparam int          FP16_BIAS = 15;
    localparam logic [14:0] FP16_QNAN = 15'h7E00;
    localparam logic [14:0] FP16_INF  = 15'h7C00;
    localparam logic [14:0] FP16_MAXF = 15'h7BFF;

    typedef struct packed {
        logic nan;
        logic ovf;
        logic unf;
        logic inexact;
    } fp_flags_t;

    typedef enum logic [1:0] {
        FPC_ZERO,
        FPC_NORM,
        FPC_INF,
        FPC_NAN
    } fp_class_t;

endpackage

// File: rtl/fp_rne_rounder.sv
// Round-to-nearest-even on an 11-bit significand given guard and sticky bits.
// o_carry flags a wrap of the significand out of its 11-bit window.
module fp_rne_rounder (
    input  logic [10:0] i_mant,
    input  logic        i_guard,
    input  logic        i_sticky,
    output logic [10:0] o_mant,
    output logic        o_carry,
    output logic        o_inexact
);

    logic w_inc;

    assign w_inc              = i_guard & (i_sticky | i_mant[0]);
    assign {o_carry, o_mant}  = {1'b0, i_mant} + {11'd0, w_inc};
    assign o_inexact          = i_guard | i_sticky;

endmodule

// File: rtl/fp32_to_fp16_packer.sv
// Two-stage valid/ready pipeline narrowing fp32 words to fp16 with RNE,
// per-result exception flags and saturating overflow/underflow counters.
module fp32_to_fp16_packer
    import fp16_pkg::*;
#(
    parameter bit SAT_EN = 1'b1,
    parameter bit FTZ    = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [3:0]       out_flags,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
);

    logic              r_v1, r_v2;
    logic              r_sign;
    fp_class_t         r_cls;
    logic signed [8:0] r_exp;
    logic [23:0]       r_sig;
    logic [3:0]        r_sh;
    logic              r_mnz;
    logic [15:0]       r_data;
    fp_flags_t         r_flags;

    logic              w_ready_s1, w_ready_s2, w_out_hs;
    fp_class_t         w_cls;
    logic signed [8:0] w_e;
    logic [3:0]        w_sh;
    logic [34:0]       w_x;
    logic [10:0]       w_rmant;
    logic              w_rcarry, w_inexact;
    logic [9:0]        w_exp16;
    logic [15:0]       w_data;
    fp_flags_t         w_flags;
    logic [1:0]        w_hit;

    assign w_ready_s2 = !r_v2 || out_ready;
    assign w_ready_s1 = !r_v1 || w_ready_s2;
    assign in_ready   = !rst && w_ready_s1;
    assign w_out_hs   = r_v2 && out_ready;

    // Stage 1: classify, unbias, and pick the subnormal denormalising shift
    assign w_e = {1'b0, in_data[30:23]} - 9'(FP32_BIAS);

    always_comb begin
        w_cls = FPC_NORM;
        if (in_data[30:23] == 8'hFF) begin
            w_cls = (in_data[22:0] != 23'd0) ? FPC_NAN : FPC_INF;
        end else if (in_data[30:23] == 8'h00) begin
            w_cls = FPC_ZERO;
        end
    end

    // Shift 12 parks the hidden bit in the sticky field, which yields zero+inexact
    always_comb begin
        w_sh = 4'd0;
        if (w_e < -9'sd25) begin
            w_sh = 4'd12;
        end else if (w_e < -9'sd14) begin
            w_sh = 4'(-9'sd14 - w_e);
        end
    end

    // Stage 2: align into an 11-bit window + guard + sticky, round, pack
    assign w_x = {r_sig, 11'd0} >> r_sh;

    fp_rne_rounder u_rnd (
        .i_mant    (w_x[34:24]),
        .i_guard   (w_x[23]),
        .i_sticky  (|w_x[22:0]),
        .o_mant    (w_rmant),
        .o_carry   (w_rcarry),
        .o_inexact (w_inexact)
    );

    assign w_exp16 = {r_exp[8], r_exp} + 10'(FP16_BIAS) + {9'd0, w_rcarry};

    always_comb begin
        w_data  = '0;
        w_flags = '0;
        case (r_cls)
            FPC_NAN: begin
                w_data      = {r_sign, FP16_QNAN};
                w_flags.nan = 1'b1;
            end
            FPC_INF: begin
                w_data = {r_sign, FP16_INF};
            end
            FPC_ZERO: begin
                w_data          = {r_sign, 15'd0};
                w_flags.unf     = r_mnz;
                w_flags.inexact = r_mnz;
            end
            FPC_NORM: begin
                if (r_exp > 9'sd15 || (r_sh == 4'd0 && w_exp16 >= 10'd31)) begin
                    w_data          = {r_sign, (SAT_EN ? FP16_MAXF : FP16_INF)};
                    w_flags.ovf     = 1'b1;
                    w_flags.inexact = 1'b1;
                end else if (r_sh == 4'd0) begin
                    w_data          = {r_sign, w_exp16[4:0], w_rmant[9:0]};
                    w_flags.inexact = w_inexact;
                end else if (FTZ && !w_rmant[10]) begin
                    w_data          = {r_sign, 15'd0};
                    w_flags.unf     = 1'b1;
                    w_flags.inexact = 1'b1;
                end else begin
                    // A round-up into bit 10 lands exactly on the smallest normal
                    w_data          = {r_sign, 4'd0, w_rmant};
                    w_flags.unf     = !w_rmant[10] && w_inexact;
                    w_flags.inexact = w_inexact;
                end
            end
            default: begin
                w_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_sign  <= 1'b0;
            r_cls   <= FPC_ZERO;
            r_exp   <= '0;
            r_sig   <= '0;
            r_sh    <= '0;
            r_mnz   <= 1'b0;
            r_data  <= '0;
            r_flags <= '0;
        end else begin
            if (w_ready_s1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    r_sign <= in_data[31];
                    r_cls  <= w_cls;
                    r_exp  <= w_e;
                    r_sig  <= {1'b1, in_data[22:0]};
                    r_sh   <= w_sh;
                    r_mnz  <= (in_data[22:0] != 23'd0);
                end
            end
            if (w_ready_s2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_data  <= w_data;
                    r_flags <= w_flags;
                end
            end
        end
    end

    // Counter 0 tracks ovf, counter 1 tracks unf; clear beats increment
    assign w_hit = {r_flags.unf, r_flags.ovf};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (rst || cnt_clr) begin
                    r_cnt <= '0;
                end else if (w_out_hs && w_hit[gi] && r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign out_valid = r_v2;
    assign out_data  = r_data;
    assign out_flags = r_flags;
    assign ovf_cnt   = g_cnt[0].r_cnt;
    assign unf_cnt   = g_cnt[1].r_cnt;

endmodule

// File: tb/tb_fp32_to_fp16_packer.sv
// Randomised bench for fp32_to_fp16_packer: exact-arithmetic reference model,
// scoreboard on every output handshake, directed corner vectors and backpressure.
module tb_fp32_to_fp16_packer;

    localparam int CW  = 4;
    localparam bit SAT = 1'b1;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [31:0]   in_data;
    logic [15:0]   out_data;
    logic [3:0]    out_flags;
    logic [CW-1:0] ovf_cnt, unf_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp32_to_fp16_packer #(.SAT_EN(SAT), .FTZ(1'b0), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_flags (out_flags),
        .cnt_clr   (cnt_clr),
        .ovf_cnt   (ovf_cnt),
        .unf_cnt   (unf_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Reference: value = m * 2^(e-23); quantise to the fp16 ulp 2^qe with exact integers
    function automatic logic [19:0] model(input logic [31:0] x);
        logic               s;
        int                 ex, e, qe, sh;
        longint unsigned    m, q, rem, half;
        logic               inx;
        s  = x[31];
        ex = int'(x[30:23]);
        if (ex == 255) return (x[22:0] != 0) ? {s, 15'h7E00, 4'b1000} : {s, 15'h7C00, 4'b0000};
        if (ex == 0)   return (x[22:0] != 0) ? {s, 15'h0000, 4'b0011} : {s, 15'h0000, 4'b0000};
        e  = ex - 127;
        m  = {40'd0, 1'b1, x[22:0]};
        qe = (e - 10 > -24) ? e - 10 : -24;
        sh = qe - (e - 23);
        if (sh > 40) begin
            q   = 0;
            inx = 1'b1;
        end else begin
            q    = m >> sh;
            rem  = m - (q << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 1;
        end
        if (q >= 2048) begin
            q  = q >> 1;
            qe = qe + 1;
        end
        if (q >= 1024) begin
            if (qe + 25 >= 31) return {s, (SAT ? 15'h7BFF : 15'h7C00), 4'b0101};
            return {s, 5'(qe + 25), 10'(q - 1024), 3'b000, inx};
        end
        return {s, 5'd0, 10'(q), 2'b00, inx, inx};
    endfunction

    function automatic logic [31:0] gen();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       w[30:23] = 8'hFF;
            1:       w[30:23] = 8'h00;
            2, 3:    w[30:23] = 8'($urandom_range(101, 113));
            4, 5:    w[30:23] = 8'($urandom_range(138, 145));
            6, 7:    w[30:23] = 8'($urandom_range(112, 142));
            default: w = w;
        endcase
        if ($urandom_range(0, 3) == 0) w[12:0] = 13'h1000;
        return w;
    endfunction

    // Scoreboard / compare process
    logic [19:0]   exp_q[$];
    logic [19:0]   exp_w;
    logic [CW-1:0] m_ovf = '0;
    logic [CW-1:0] m_unf = '0;
    logic          prev_stall = 1'b0;
    logic [15:0]   prev_data = '0;
    logic          hs_out;
    int            txn = 0;

    always @(negedge clk) begin
        chk("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
        chk("unf_cnt", 32'(unf_cnt), 32'(m_unf));
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            exp_q.delete();
            m_ovf      = '0;
            m_unf      = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(prev_data));
            end
            exp_w  = '0;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h required no output", out_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: out_data=%h flags=%b expect %h/%b", txn, out_data, out_flags,
                             exp_w[19:4], exp_w[3:0]);
                    chk("out_data", 32'(out_data), 32'(exp_w[19:4]));
                    chk("out_flags", 32'(out_flags), 32'(exp_w[3:0]));
                end
            end
            if (cnt_clr) begin
                m_ovf = '0;
                m_unf = '0;
            end else begin
                if (hs_out && exp_w[2] && m_ovf != '1) m_ovf = m_ovf + 1'b1;
                if (hs_out && exp_w[1] && m_unf != '1) m_unf = m_unf + 1'b1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) exp_q.push_back(model(in_data));
        end
    end

    task automatic send(input logic [31:0] w);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    logic [31:0] dir_vec [11] = '{32'h3F800000, 32'h3F801000, 32'h3F803000, 32'hBF807000,
                                  32'h477FF000, 32'h33800000, 32'h33000000, 32'h387FE000,
                                  32'hFFC00001, 32'h7F800000, 32'h00000001};
    logic [19:0] dir_exp [11] = '{20'h3C000, 20'h3C001, 20'h3C021, 20'hBC041,
                                  20'h7BFF5, 20'h00010, 20'h00003, 20'h04001,
                                  20'hFE008, 20'h7C000, 20'h00003};
    logic [31:0] bp_vec  [6]  = '{32'h3F800000, 32'h3F803000, 32'h33800000,
                                  32'hC0000000, 32'h477FF000, 32'h387FE000};
    int   acc, idx, sent, guard;
    logic hs_in;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;

        for (int i = 0; i < 11; i++) chk("model_pin", 32'(model(dir_vec[i])), 32'(dir_exp[i]));

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Latency: handshake edge, then out_valid one edge later (two register stages)
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_data", 32'(out_data), 32'h3C00);
        drain();

        for (int i = 0; i < 11; i++) send(dir_vec[i]);
        drain();
        chk("dir_ovf_cnt", 32'(ovf_cnt), 32'd1);
        chk("dir_unf_cnt", 32'(unf_cnt), 32'd2);

        // Backpressure: only two words fit while the consumer stalls
        @(posedge clk);
        #1;
        acc       = 0;
        idx       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = bp_vec[0];
        repeat (5) begin
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) in_data = bp_vec[idx];
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        while (idx < 6) begin
            send(bp_vec[idx]);
            idx++;
        end
        drain();

        // Counter clear coinciding with an overflow handshake
        out_ready = 1'b0;
        send(32'h477FF000);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        chk("clr_word_ready", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_ovf_cnt", 32'(ovf_cnt), 32'd0);

        // Reset with words in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h3F800000);
        send(32'h3F803000);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);

        // Randomised traffic with random stalls and occasional counter clears
        @(posedge clk);
        #1;
        sent  = 0;
        guard = 0;
        hs_in = 1'b0;
        while (sent < 600 && guard < 20000) begin
            if (hs_in) sent++;
            if (!in_valid || hs_in) begin
                in_valid = ($urandom_range(0, 3) != 0) && (sent < 600);
                in_data  = gen();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clr   = ($urandom_range(0, 50) == 0);
            @(negedge clk);
            hs_in = in_valid && in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        chk("random_sent", 32'(sent), 32'd600);
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

endmodule
